// File: rtl/timer_counter.sv
// timer_counter: programmable 32-bit down-counting timer with a register window.
// Registers: CTRL (EN, MODE, IM), PRESET (reload value), COUNT (read-only).
// IRQ is a level interrupt request (IM & irq_pend) feeding one CP0 HWInt bit.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | stopped; COUNT holds; leaves when EN is set
// LOAD  | COUNT takes PRESET
// CNT   | counting down; reaching 1 or 0 raises irq_pend
// INT   | terminal count seen; auto-reload restarts, one-shot clears EN
module timer_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:2]  Addr,
    input  logic        Wen,
    input  logic [31:0] DIn,
    output logic [31:0] DOut,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic [31:0] count_nxt;
    logic        irq_pend;
    logic        pend_set;
    logic        pend_clr_fsm;
    logic        en_clr;
    logic        en;
    logic        auto_reload;
    logic        im;
    logic        wr_ctrl;
    logic        wr_preset;

    // CTRL bit layout: [0] EN, [2:1] MODE, [3] IM; only MODE 01 reloads
    assign en          = ctrl[0];
    assign auto_reload = (ctrl[2:1] == 2'b01);
    assign im          = ctrl[3];

    assign wr_ctrl   = Wen && (Addr == 2'd0);
    assign wr_preset = Wen && (Addr == 2'd1);

    assign IRQ = im & irq_pend;

    // Next-state and counter datapath decisions
    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        pend_set     = 1'b0;
        pend_clr_fsm = 1'b0;
        en_clr       = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                count_nxt = preset;
                state_nxt = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (count > 32'd1) begin
                    count_nxt = count - 32'd1;
                end else begin
                    // A count of 0 (PRESET = 0) terminates like a count of 1
                    count_nxt = 32'd0;
                    pend_set  = 1'b1;
                    state_nxt = INT;
                end
            end
            INT: begin
                if (auto_reload) begin
                    pend_clr_fsm = 1'b1;
                    state_nxt    = LOAD;
                end else begin
                    en_clr    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state and COUNT registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            count <= 32'd0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // CTRL: a software write beats the one-shot EN clear in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl <= 4'd0;
        end else if (wr_ctrl) begin
            ctrl <= DIn[3:0];
        end else if (en_clr) begin
            ctrl[0] <= 1'b0;
        end
    end

    // PRESET is only sampled at LOAD, so a write never disturbs a running count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            preset <= 32'd0;
        end else if (wr_preset) begin
            preset <= DIn;
        end
    end

    // Pending flag: a terminal-count set beats a same-cycle clearing write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_pend <= 1'b0;
        end else if (pend_set) begin
            irq_pend <= 1'b1;
        end else if (wr_ctrl || wr_preset || pend_clr_fsm) begin
            irq_pend <= 1'b0;
        end
    end

    // Combinational read mux; Addr 3 reads zero
    always_comb begin
        DOut = 32'd0;
        case (Addr)
            2'd0:    DOut = {28'd0, ctrl};
            2'd1:    DOut = preset;
            2'd2:    DOut = count;
            default: DOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed stimulus, a cycle model of the timer's programmer-visible
// behaviour checked every falling edge, plus hand-computed literal checkpoints.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:2]  Addr;
    logic        Wen;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic        IRQ;

    int n_checks = 0;
    int n_fail   = 0;

    timer_counter dut (
        .clk  (clk),
        .rst  (rst),
        .Addr (Addr),
        .Wen  (Wen),
        .DIn  (DIn),
        .DOut (DOut),
        .IRQ  (IRQ)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_pend;
    logic        m_load_due;   // the coming edge copies PRESET into COUNT
    logic        m_running;    // COUNT is decrementing
    logic        m_fired;      // terminal count was reached on the last edge

    function automatic logic [31:0] m_dout(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin : model_step
        logic [3:0]  c;
        logic [31:0] cnt;
        logic        p;
        logic        ld;
        logic        run;
        logic        fired;
        logic        set_now;
        if (!rst) begin
            m_ctrl     = 4'd0;
            m_preset   = 32'd0;
            m_count    = 32'd0;
            m_pend     = 1'b0;
            m_load_due = 1'b0;
            m_running  = 1'b0;
            m_fired    = 1'b0;
        end else begin
            c       = m_ctrl;
            cnt     = m_count;
            p       = m_pend;
            ld      = 1'b0;
            run     = m_running;
            fired   = 1'b0;
            set_now = 1'b0;
            if (m_fired) begin
                if (m_ctrl[2:1] == 2'b01) begin
                    p  = 1'b0;
                    ld = 1'b1;
                end else begin
                    c[0] = 1'b0;
                end
            end else if (m_load_due) begin
                cnt = m_preset;
                run = 1'b1;
            end else if (m_running) begin
                if (!m_ctrl[0]) begin
                    run = 1'b0;
                end else if (m_count > 32'd1) begin
                    cnt = m_count - 32'd1;
                end else begin
                    cnt     = 32'd0;
                    p       = 1'b1;
                    set_now = 1'b1;
                    fired   = 1'b1;
                    run     = 1'b0;
                end
            end else if (m_ctrl[0]) begin
                ld = 1'b1;
            end
            if (Wen && Addr == 2'd0) c = DIn[3:0];
            if (Wen && Addr <= 2'd1 && !set_now) p = 1'b0;
            if (Wen && Addr == 2'd1) m_preset = DIn;
            m_ctrl     = c;
            m_count    = cnt;
            m_pend     = p;
            m_load_due = ld;
            m_running  = run;
            m_fired    = fired;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every falling edge: DUT read path and IRQ against the model
    always @(negedge clk) begin
        chk("model_dout", DOut, m_dout(Addr));
        chk("model_irq", {31'd0, IRQ}, {31'd0, m_ctrl[3] & m_pend});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        DIn  = d;
        Wen  = 1'b1;
        tick();
        Wen  = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        Addr = a;
        #1;
        chk(name, DOut, exp);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        Addr = 2'd0;
        Wen  = 1'b0;
        DIn  = 32'd0;
        rst  = 1'b0;
        #1;
        chk("rst_irq", {31'd0, IRQ}, 32'd0);
        rd(2'd0, 32'd0, "rst_ctrl");
        rd(2'd1, 32'd0, "rst_preset");
        rd(2'd2, 32'd0, "rst_count");
        #9 rst = 1'b1;
        tick();

        // one-shot, PRESET = 3: COUNT 3,2,1,0 at t0+2..t0+5, IRQ from t0+5
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        tick(); tick();
        rd(2'd2, 32'd3, "os_count3");
        chk("os_irq_low", {31'd0, IRQ}, 32'd0);
        tick(); rd(2'd2, 32'd2, "os_count2");
        tick(); rd(2'd2, 32'd1, "os_count1");
        chk("os_irq_before", {31'd0, IRQ}, 32'd0);
        tick(); rd(2'd2, 32'd0, "os_count0");
        chk("os_irq_rise", {31'd0, IRQ}, 32'd1);
        tick();
        rd(2'd0, 32'h8, "os_ctrl_en_cleared");
        chk("os_irq_held", {31'd0, IRQ}, 32'd1);
        wr(2'd1, 32'd5);
        chk("os_irq_cleared", {31'd0, IRQ}, 32'd0);
        tick();

        // auto-reload, PRESET = 2: 1-cycle pulses at t0+4, t0+8, t0+12
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        Addr = 2'd2;
        for (int k = 1; k <= 13; k++) begin
            tick();
            chk("ar_irq", {31'd0, IRQ}, (k % 4 == 0) ? 32'd1 : 32'd0);
        end
        rd(2'd0, 32'hB, "ar_en_kept");
        wr(2'd0, 32'd0);
        repeat (4) tick();

        // masked one-shot: pend sets silently, then a CTRL write clears it
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h1);
        repeat (5) tick();
        chk("mask_irq_low", {31'd0, IRQ}, 32'd0);
        wr(2'd0, 32'h8);
        chk("mask_unmask_irq", {31'd0, IRQ}, 32'd0);
        tick();
        chk("mask_unmask_irq2", {31'd0, IRQ}, 32'd0);
        rd(2'd0, 32'h8, "mask_ctrl");

        // disable while counting freezes COUNT; re-enable reloads PRESET
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        repeat (5) tick();
        rd(2'd2, 32'd7, "frz_count7");
        wr(2'd0, 32'h0);
        repeat (3) tick();
        rd(2'd2, 32'd6, "frz_held");
        wr(2'd0, 32'h1);
        tick(); tick();
        rd(2'd2, 32'd10, "frz_reload");
        wr(2'd1, 32'd99);
        rd(2'd2, 32'd9, "preset_wr_no_effect");
        wr(2'd0, 32'h0);
        repeat (3) tick();

        // PRESET = 0 behaves as 1: IRQ at t0+3
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        tick(); tick();
        chk("p0_irq_low", {31'd0, IRQ}, 32'd0);
        tick();
        chk("p0_irq_t3", {31'd0, IRQ}, 32'd1);
        wr(2'd1, 32'd0);
        tick();

        // PRESET = max decrements without wrap; COUNT and Addr 3 ignore writes
        wr(2'd1, 32'hFFFF_FFFF);
        wr(2'd0, 32'h1);
        tick(); tick();
        rd(2'd2, 32'hFFFF_FFFF, "max_load");
        tick(); rd(2'd2, 32'hFFFF_FFFE, "max_dec1");
        tick(); rd(2'd2, 32'hFFFF_FFFD, "max_dec2");
        wr(2'd2, 32'h0000_1234);
        rd(2'd2, 32'hFFFF_FFFC, "count_wr_ignored");
        wr(2'd3, 32'h0000_ABCD);
        rd(2'd3, 32'd0, "addr3_reads_zero");
        rd(2'd2, 32'hFFFF_FFFB, "addr3_wr_ignored");
        rd(2'd1, 32'hFFFF_FFFF, "addr3_preset_intact");
        wr(2'd0, 32'h0);
        repeat (3) tick();

        // CTRL write on the INT edge keeps the written EN
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        repeat (3) tick();
        chk("race_irq_t3", {31'd0, IRQ}, 32'd1);
        wr(2'd0, 32'h9);
        rd(2'd0, 32'h9, "race_en_kept");
        chk("race_pend_cleared", {31'd0, IRQ}, 32'd0);
        wr(2'd0, 32'h0);
        repeat (3) tick();

        // asynchronous reset mid-count at COUNT = 5
        wr(2'd1, 32'd8);
        wr(2'd0, 32'h9);
        repeat (5) tick();
        rd(2'd2, 32'd5, "pre_rst_count5");
        rst = 1'b0;
        #1;
        chk("arst_count", DOut, 32'd0);
        chk("arst_irq", {31'd0, IRQ}, 32'd0);
        rd(2'd0, 32'd0, "arst_ctrl");
        rd(2'd1, 32'd0, "arst_preset");
        #2 rst = 1'b1;
        repeat (3) tick();
        rd(2'd2, 32'd0, "post_rst_count");

        #20;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
